submod_sec: RTL and testbench
=============================

// Module: submod_sec
// PURPOSE
//   Seconds stage of the digital timer: divides the system clock down to a 1 Hz tick,
//   keeps a BCD seconds count 00-59, and drives the seconds-low/high seven-segment codes
//   that the minute-low stage consumes. Adds a start/stop/clear run-control FSM and a
//   one-cycle minute-carry pulse so downstream stages can advance exactly once per wrap.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per 1 s tick (>=2); benches override to 4
//   PRE_W     26          prescaler width; 2**PRE_W >= TICK_DIV
// PORTS
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset, all state
//   dsyn_rst_n     in   1  synchronised active-low display enable; low blanks SSD outputs
//   start          in   1  one-cycle pulse: IDLE/PAUSE -> RUN
//   stop           in   1  one-cycle pulse: RUN -> PAUSE
//   clear          in   1  one-cycle pulse: any state -> IDLE, count 00
//   ssd_sec_l_sub  out  7  seconds-low segment code (`ZERO..`NINE)
//   ssd_sec_h_sub  out  7  seconds-high segment code (`ZERO..`FIVE)
//   sec_carry      out  1  one-cycle pulse on 59->00 wrap
//   running        out  1  high while FSM in RUN
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, prescaler=0, sec_l=0, sec_h=0, sec_carry=0,
//     running=0; SSD outputs decode to `ZERO (or 7'd0 if dsyn_rst_n low).
//   FSM states IDLE, RUN, PAUSE; control priority clear > stop > start, sampled each edge.
//     IDLE : start -> RUN; stop ignored; clear -> IDLE (re-zero).
//     RUN  : clear -> IDLE; stop -> PAUSE; start ignored.
//     PAUSE: clear -> IDLE; start -> RUN; stop ignored.
//   running is registered state==RUN: high the cycle after the start pulse.
//   Prescaler: counts only in RUN; tick when prescaler==TICK_DIV-1 and state is RUN, with no
//     clear/stop that cycle; prescaler wraps to 0 on tick. Holds value in PAUSE (phase kept);
//     forced to 0 in IDLE. First tick after start at cycle N: edge N+TICK_DIV.
//   Count on tick: sec_l==9 -> sec_l=0 and (sec_h==5 ? sec_h=0 : sec_h+1); else sec_l+1.
//     sec_l 4-bit 0..9, sec_h 3-bit 0..5; out-of-range codes unreachable, decode default 7'd0.
//   sec_carry: registered, high for exactly the one cycle in which count first reads 00
//     after a 59 tick; never high on clear, reset, or start.
//   Simultaneous: clear on tick cycle -> count 00, no carry; stop on tick cycle -> no
//     increment, PAUSE, prescaler holds at TICK_DIV-1 (next start ticks next edge).
//   SSD decode combinational from sec_l/sec_h; dsyn_rst_n low forces both to 7'd0 while
//     counting continues unaffected.
//   Downstream contract: at tick rate 1 Hz the 59 display persists TICK_DIV cycles;
//     minute stages advance on sec_carry, not on the 59 display code.
// TESTING (TICK_DIV=4)
//   Reset release, no start, 20 cycles -> SSD both `ZERO, running=0, sec_carry never high.
//   start pulse, run 40 cycles -> running=1 from next edge, ssd_sec_h=`ONE, ssd_sec_l=`ZERO.
//   Run to 59, next tick -> SSD `ZERO/`ZERO, sec_carry high exactly 1 cycle, then 0.
//   stop at 07 mid-prescale, idle 20 cycles -> holds 07; start -> 08 after remaining cycles.
//   clear with stop together in RUN -> IDLE, 00; clear on tick cycle at 59 -> 00, no carry.
//   dsyn_rst_n low 12 cycles -> SSD 7'd0 but count +3; rst_n low mid-RUN -> async 00, IDLE.

Source files
------------

// File: rtl/submod_sec.sv
// ---------------------------------------------------------------------------
// submod_sec -- seconds stage of the digital timer
//
// Divides the system clock down to a 1 s tick, keeps a BCD seconds count
// 00..59 and presents it as two seven-segment codes for the minute stage.
// A start/stop/clear run-control FSM gates the count, and a one-cycle
// sec_carry pulse marks each 59 -> 00 wrap so the minute stage advances
// exactly once per minute.
//
// Parameters
//   TICK_DIV  clk cycles per seconds tick (>= 2)
//   PRE_W     prescaler width, 2**PRE_W >= TICK_DIV
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset of all state
//   dsyn_rst_n     in   1  display enable, low blanks both segment outputs
//   start          in   1  one-cycle pulse, IDLE/PAUSE -> RUN
//   stop           in   1  one-cycle pulse, RUN -> PAUSE
//   clear          in   1  one-cycle pulse, any state -> IDLE with count 00
//   ssd_sec_l_sub  out  7  seconds-low segment code
//   ssd_sec_h_sub  out  7  seconds-high segment code
//   sec_carry      out  1  one-cycle pulse in the first cycle reading 00
//                          after a 59 tick
//   running        out  1  high while the FSM is in RUN
//   dbg_state      out  2  current FSM state (0 IDLE, 1 RUN, 2 PAUSE)
//
// Control handshake: start/stop/clear are level samples taken on every
// rising clk edge; there is no ready/acknowledge. A pulse asserted across
// several edges is acted on at each of those edges. When more than one is
// high in the same cycle only the highest priority one (clear > stop >
// start) is considered; a command meaningless in the current state is
// dropped.
//
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}; an all-zero
// code is a blank digit.
// ---------------------------------------------------------------------------
module submod_sec #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dsyn_rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [6:0] ssd_sec_l_sub,
    output logic [6:0] ssd_sec_h_sub,
    output logic       sec_carry,
    output logic       running,
    output logic [1:0] dbg_state
);

    // Segment patterns, {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_ONE   = 7'h06;
    localparam logic [6:0] SEG_TWO   = 7'h5B;
    localparam logic [6:0] SEG_THREE = 7'h4F;
    localparam logic [6:0] SEG_FOUR  = 7'h66;
    localparam logic [6:0] SEG_FIVE  = 7'h6D;
    localparam logic [6:0] SEG_SIX   = 7'h7D;
    localparam logic [6:0] SEG_SEVEN = 7'h07;
    localparam logic [6:0] SEG_EIGHT = 7'h7F;
    localparam logic [6:0] SEG_NINE  = 7'h6F;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [3:0]       sec_l_q, sec_l_d;
    logic [2:0]       sec_h_q, sec_h_d;
    logic             carry_q, carry_d;
    logic             running_q, running_d;

    // Prioritised command decode: at most one of these is high.
    logic cmd_clear;
    logic cmd_stop;
    logic cmd_start;
    logic tick;

    assign cmd_clear = clear;
    assign cmd_stop  = !clear && stop;
    assign cmd_start = !clear && !stop && start;

    // A tick is suppressed by clear or stop in the same cycle: clear wins
    // outright, and stop freezes the prescaler at its last value so the
    // pending tick fires on the first RUN edge after the next start.
    assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST) && !clear && !stop;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sec_l_d   = sec_l_q;
        sec_h_d   = sec_h_q;
        carry_d   = 1'b0;
        running_d = 1'b0;

        // Next FSM state.
        if (cmd_clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (cmd_start) state_d = ST_RUN;
                ST_RUN:   if (cmd_stop)  state_d = ST_PAUSE;
                ST_PAUSE: if (cmd_start) state_d = ST_RUN;
                default:                 state_d = ST_IDLE;
            endcase
        end

        // Prescaler: zero whenever the FSM is (or is entering) IDLE, counts
        // only through uninterrupted RUN cycles, holds otherwise so a pause
        // keeps the phase of the current second.
        if (state_d == ST_IDLE) begin
            pre_d = '0;
        end else if (state_q == ST_RUN && !cmd_stop) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end

        // BCD seconds count.
        if (cmd_clear) begin
            sec_l_d = 4'd0;
            sec_h_d = 3'd0;
        end else if (tick) begin
            if (sec_l_q == 4'd9) begin
                sec_l_d = 4'd0;
                sec_h_d = (sec_h_q == 3'd5) ? 3'd0 : sec_h_q + 3'd1;
            end else begin
                sec_l_d = sec_l_q + 4'd1;
            end
        end

        // Carry goes high together with the 00 that the wrap produces.
        carry_d   = tick && (sec_l_q == 4'd9) && (sec_h_q == 3'd5);
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            sec_l_q   <= 4'd0;
            sec_h_q   <= 3'd0;
            carry_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sec_l_q   <= sec_l_d;
            sec_h_q   <= sec_h_d;
            carry_q   <= carry_d;
            running_q <= running_d;
        end
    end

    // Digit to segment decode; codes above nine show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = SEG_ONE;
            4'd2:    seg = SEG_TWO;
            4'd3:    seg = SEG_THREE;
            4'd4:    seg = SEG_FOUR;
            4'd5:    seg = SEG_FIVE;
            4'd6:    seg = SEG_SIX;
            4'd7:    seg = SEG_SEVEN;
            4'd8:    seg = SEG_EIGHT;
            4'd9:    seg = SEG_NINE;
            default: seg = 7'd0;
        endcase
        return seg;
    endfunction

    // Blanking only affects the display path; the count keeps running.
    assign ssd_sec_l_sub = dsyn_rst_n ? seg_decode(sec_l_q)         : 7'd0;
    assign ssd_sec_h_sub = dsyn_rst_n ? seg_decode({1'b0, sec_h_q}) : 7'd0;

    assign sec_carry = carry_q;
    assign running   = running_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_submod_sec.sv
// ---------------------------------------------------------------------------
// tb_submod_sec -- bench for the seconds stage with TICK_DIV = 4.
// The reference model keeps the time as a plain integer 0..59 plus a count
// of run cycles into the current second; display digits are derived with
// /10 and %10. Each driven cycle pushes the expected outputs into exp_q and
// a monitor process pops and compares them shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_submod_sec;

    localparam int TICK_DIV = 4;
    localparam int PRE_W    = 4;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_PAUSE = 2;

    // ---------------- clock / reset ----------------
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       dsyn_rst_n = 1'b1;
    logic       start      = 1'b0;
    logic       stop       = 1'b0;
    logic       clear      = 1'b0;
    logic [6:0] ssd_sec_l_sub;
    logic [6:0] ssd_sec_h_sub;
    logic       sec_carry;
    logic       running;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    submod_sec #(
        .TICK_DIV (TICK_DIV),
        .PRE_W    (PRE_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dsyn_rst_n    (dsyn_rst_n),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .ssd_sec_l_sub (ssd_sec_l_sub),
        .ssd_sec_h_sub (ssd_sec_h_sub),
        .sec_carry     (sec_carry),
        .running       (running),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int m_mode;
    int m_secs;
    int m_phase;
    bit m_carry;

    function automatic void model_reset();
        m_mode  = MODE_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_carry = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit p, input bit c);
        m_carry = 1'b0;
        if (c) begin
            m_mode  = MODE_IDLE;
            m_secs  = 0;
            m_phase = 0;
        end else if (m_mode == MODE_RUN) begin
            if (p) begin
                m_mode = MODE_PAUSE;
            end else begin
                m_phase = m_phase + 1;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_secs  = (m_secs + 1) % 60;
                    m_carry = (m_secs == 0);
                end
            end
        end else if (!p && s) begin
            m_mode = MODE_RUN;
        end
    endfunction

    function automatic logic [15:0] model_outputs(input bit d);
        logic [6:0] lo;
        logic [6:0] hi;
        lo = d ? seg_tbl[m_secs % 10] : 7'd0;
        hi = d ? seg_tbl[m_secs / 10] : 7'd0;
        return {lo, hi, m_carry, (m_mode == MODE_RUN)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    always @(posedge clk) begin
        logic [15:0] e;
        logic [15:0] a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ssd_sec_l_sub, ssd_sec_h_sub, sec_carry, running};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle t=%0t got l=%h h=%h carry=%b run=%b exp l=%h h=%h carry=%b run=%b",
                         $time, a[15:9], a[8:2], a[1], a[0], e[15:9], e[8:2], e[1], e[0]);
            end
        end
    end

    task automatic check_direct(input string name, input logic [15:0] e);
        logic [15:0] a;
        a = {ssd_sec_l_sub, ssd_sec_h_sub, sec_carry, running};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s got l=%h h=%h carry=%b run=%b exp l=%h h=%h carry=%b run=%b",
                     name, a[15:9], a[8:2], a[1], a[0], e[15:9], e[8:2], e[1], e[0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit s, input bit p, input bit c, input bit d);
        @(negedge clk);
        start      = s;
        stop       = p;
        clear      = c;
        dsyn_rst_n = d;
        @(posedge clk);
        model_step(s, p, c);
        exp_q.push_back(model_outputs(d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] zero_out;
        zero_out = {7'h3F, 7'h3F, 1'b0, 1'b0};
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1 check_direct("reset", zero_out);
        @(negedge clk);
        rst_n = 1'b1;

        // No start: stays at 00, never running, never carries.
        idle(20);

        // Start, 40 cycles -> 10 seconds.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(40);

        // Continue through 59 and the wrap to 00 with its carry pulse.
        idle(200);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);

        // Stop at 07 partway into the second, wait, resume.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(29);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(20);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Clear and stop together while running.
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);

        // Clear exactly on the tick that would wrap 59 -> 00.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(239);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle(8);

        // Stop on a tick cycle: no increment, next start ticks at once.
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(5);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Display blanked for 12 cycles while the count advances.
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Random control traffic.
        for (int i = 0; i < 700; i++) begin
            int r;
            bit s;
            bit p;
            bit c;
            bit d;
            r = $urandom_range(0, 99);
            s = (r < 8);
            p = (r >= 8 && r < 13);
            c = (r >= 98);
            d = ($urandom_range(0, 5) != 0);
            cycle(s, p, c, d);
        end

        // Asynchronous reset in the middle of RUN.
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(10);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_direct("async_reset", zero_out);
        repeat (2) @(posedge clk);
        #1 check_direct("reset_held", zero_out);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        idle(9);

        // Every pushed expectation must have been consumed.
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
